// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multi-cycle MIPS control FSM
//
// Purpose: sequences fetch/decode/execute/memory/writeback for the multi-cycle
//   MIPS datapath. Decodes opcode/funct, drives PC, IR, register-file, ALU-mux
//   and memory strobes, and selects sign vs zero extension of the immediate.
//   Memory accesses use a single-beat req/ready handshake; the FSM holds the
//   request stable until ready.
//
// Optional feature: define PERF_CNT_EN to add cycle_cnt/retire_cnt outputs.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   opcode, funct         IR[31:26], IR[5:0]
//   zero                  ALU zero flag
//   mem_ready             memory done (read data valid / write accepted)
//   mem_req, mem_we, iord memory request, write select, address select
//   ir_we, pc_we, pc_src  IR load, PC load, PC source select
//   reg_we, reg_dst       register write enable, destination select
//   mem_to_reg            writeback data select
//   alu_src_a, alu_src_b  ALU operand selects
//   alu_op                000 ADD, 001 SUB, 010 XOR, 011 SLT
//   ext_zero              1 = zero-extend immediate
//   illegal               sticky unsupported-instruction flag
//   state                 current state encoding
//   cycle_cnt, retire_cnt performance counters (PERF_CNT_EN only)

module mips_multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             iord,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_src,
   output logic             reg_we,
   output logic [1:0]       reg_dst,
   output logic [1:0]       mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_op,
   output logic             ext_zero,
   output logic             illegal,
   output logic [3:0]       state
`ifdef PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] retire_cnt
`endif
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXR    = 4'd6,
      S_RWB    = 4'd7,
      S_EXI    = 4'd8,
      S_IWB    = 4'd9,
      S_BRANCH = 4'd10,
      S_JUMP   = 4'd11,
      S_JAL    = 4'd12,
      S_JR     = 4'd13,
      S_HALT   = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_XOR  = 3'b010;
   localparam logic [2:0] ALU_SLT  = 3'b011;

   if (CNT_W < 1) begin : g_cnt_w_check
      $error("CNT_W must be at least 1");
   end

   state_t state_q, state_d;
   logic   illegal_q;

   function automatic state_t dispatch(input logic [5:0] op, input logic [5:0] fn);
      state_t nxt;
      nxt = S_HALT;
      case (op)
         OP_RTYPE: begin
            if (fn == FN_ADD || fn == FN_SUB || fn == FN_SLT) nxt = S_EXR;
            else if (fn == FN_JR)                             nxt = S_JR;
         end
         OP_LW, OP_SW:     nxt = S_MEMADR;
         OP_ADDI, OP_XORI: nxt = S_EXI;
         OP_BEQ, OP_BNE:   nxt = S_BRANCH;
         OP_J:             nxt = S_JUMP;
         OP_JAL:           nxt = S_JAL;
         default:          nxt = S_HALT;
      endcase
      return nxt;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_d == S_HALT) illegal_q <= 1'b1;
      end
   end

   // Every output is forced low while reset is high so an in-flight memory
   // access is abandoned in the very cycle reset is asserted.
   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = 2'd0;
      reg_we     = 1'b0;
      reg_dst    = 2'd0;
      mem_to_reg = 2'd0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      alu_op     = ALU_ADD;
      ext_zero   = 1'b0;
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               mem_req   = 1'b1;
               alu_src_b = 2'd1;
               if (mem_ready) begin
                  ir_we   = 1'b1;
                  pc_we   = 1'b1;
                  state_d = S_DECODE;
               end
            end
            S_DECODE: begin
               // Branch target is computed speculatively into ALUOut here.
               alu_src_b = 2'd3;
               state_d   = dispatch(opcode, funct);
            end
            S_MEMADR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'd2;
               state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
               mem_req = 1'b1;
               iord    = 1'b1;
               if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
               reg_we     = 1'b1;
               mem_to_reg = 2'd1;
               state_d    = S_FETCH;
            end
            S_MEMWR: begin
               mem_req = 1'b1;
               mem_we  = 1'b1;
               iord    = 1'b1;
               if (mem_ready) state_d = S_FETCH;
            end
            S_EXR: begin
               alu_src_a = 1'b1;
               if (funct == FN_SUB)      alu_op = ALU_SUB;
               else if (funct == FN_SLT) alu_op = ALU_SLT;
               state_d = S_RWB;
            end
            S_RWB: begin
               reg_we  = 1'b1;
               reg_dst = 2'd1;
               state_d = S_FETCH;
            end
            S_EXI: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'd2;
               if (opcode == OP_XORI) begin
                  alu_op   = ALU_XOR;
                  ext_zero = 1'b1;
               end
               state_d = S_IWB;
            end
            S_IWB: begin
               // Extension select is held so the immediate path stays stable.
               reg_we   = 1'b1;
               ext_zero = (opcode == OP_XORI);
               state_d  = S_FETCH;
            end
            S_BRANCH: begin
               alu_src_a = 1'b1;
               alu_op    = ALU_SUB;
               pc_src    = 2'd1;
               pc_we     = (opcode == OP_BNE) ? !zero : zero;
               state_d   = S_FETCH;
            end
            S_JUMP: begin
               pc_we   = 1'b1;
               pc_src  = 2'd2;
               state_d = S_FETCH;
            end
            S_JAL: begin
               pc_we      = 1'b1;
               pc_src     = 2'd2;
               reg_we     = 1'b1;
               reg_dst    = 2'd2;
               mem_to_reg = 2'd2;
               state_d    = S_FETCH;
            end
            S_JR: begin
               pc_we   = 1'b1;
               pc_src  = 2'd3;
               state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
         endcase
      end
   end

   assign state   = reset ? 4'd0 : state_q;
   assign illegal = illegal_q & ~reset;

`ifdef PERF_CNT_EN
   logic [CNT_W-1:0] cycle_q, retire_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_q  <= '0;
         retire_q <= '0;
      end else if (state_q != S_HALT) begin
         cycle_q <= cycle_q + CNT_W'(1);
         if (state_d == S_FETCH && state_q != S_FETCH) retire_q <= retire_q + CNT_W'(1);
      end
   end

   assign cycle_cnt  = reset ? '0 : cycle_q;
   assign retire_cnt = reset ? '0 : retire_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - scoreboard bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

   typedef struct packed {
      logic [3:0] st;
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       ir_we;
      logic       pc_we;
      logic [1:0] pc_src;
      logic       reg_we;
      logic [1:0] reg_dst;
      logic [1:0] m2r;
      logic       src_a;
      logic [1:0] src_b;
      logic [2:0] alu_op;
      logic       ez;
      logic       ill;
   } vec_t;

   typedef struct packed {
      logic rdy;
      logic rst;
      vec_t exp;
   } ent_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode, funct;
   logic       zero, mem_ready;
   logic       mem_req, mem_we, iord, ir_we, pc_we, reg_we, alu_src_a, ext_zero, illegal;
   logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
   logic [2:0] alu_op;
   logic [3:0] state;

   vec_t obs;
   ent_t sb[$];
   ent_t e;
   int   passed = 0;
   int   total  = 0;

   mips_multicycle_ctrl dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
      .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .ext_zero(ext_zero),
      .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   assign obs = {state, mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we,
                 reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, ext_zero, illegal};

   function automatic vec_t v(input logic [3:0] s);
      vec_t x;
      x = '0;
      x.st = s;
      return x;
   endfunction

   function automatic vec_t f_fetch(input logic rdy);
      vec_t x;
      x = v(4'd0);
      x.mem_req = 1'b1;
      x.src_b   = 2'd1;
      x.ir_we   = rdy;
      x.pc_we   = rdy;
      return x;
   endfunction

   function automatic vec_t f_decode();
      vec_t x;
      x = v(4'd1);
      x.src_b = 2'd3;
      return x;
   endfunction

   function automatic vec_t f_memadr();
      vec_t x;
      x = v(4'd2);
      x.src_a = 1'b1;
      x.src_b = 2'd2;
      return x;
   endfunction

   function automatic vec_t f_memwr();
      vec_t x;
      x = v(4'd5);
      x.mem_req = 1'b1;
      x.mem_we  = 1'b1;
      x.iord    = 1'b1;
      return x;
   endfunction

   task automatic push(input logic rdy, input logic rst, input vec_t x);
      sb.push_back({rdy, rst, x});
   endtask

   // Drive one cycle's inputs after the falling edge; outputs are sampled 1ns later.
   task automatic tick(input logic rdy, input logic rst);
      @(negedge clk);
      mem_ready = rdy;
      reset     = rst;
      #1;
   endtask

   task automatic test_reset();
      push(1'b0, 1'b1, v(4'd0));
      push(1'b1, 1'b1, v(4'd0));
      while (sb.size() != 0) begin
         e = sb.pop_front();
         tick(e.rdy, e.rst);
         total++;
         if (obs !== e.exp) $display("FAIL reset: got %h want %h", obs, e.exp);
         else passed++;
      end
   endtask

   task automatic test_rtype();
      logic [5:0] fn_tab [3] = '{6'h20, 6'h22, 6'h2A};
      logic [2:0] op_tab [3] = '{3'b000, 3'b001, 3'b011};
      vec_t x;
      for (int k = 0; k < 3; k++) begin
         opcode = 6'h00;
         funct  = fn_tab[k];
         push(1'b1, 1'b0, f_fetch(1'b1));
         push(1'b1, 1'b0, f_decode());
         x = v(4'd6); x.src_a = 1'b1; x.alu_op = op_tab[k];
         push(1'b1, 1'b0, x);
         x = v(4'd7); x.reg_we = 1'b1; x.reg_dst = 2'd1;
         push(1'b1, 1'b0, x);
         while (sb.size() != 0) begin
            e = sb.pop_front();
            tick(e.rdy, e.rst);
            total++;
            if (obs !== e.exp) $display("FAIL rtype fn=%h: got %h want %h", funct, obs, e.exp);
            else passed++;
         end
      end
   endtask

   task automatic test_load_wait();
      vec_t x;
      opcode = 6'h23;
      push(1'b1, 1'b0, f_fetch(1'b1));
      push(1'b1, 1'b0, f_decode());
      push(1'b1, 1'b0, f_memadr());
      x = v(4'd3); x.mem_req = 1'b1; x.iord = 1'b1;
      push(1'b0, 1'b0, x);
      push(1'b0, 1'b0, x);
      push(1'b0, 1'b0, x);
      push(1'b1, 1'b0, x);
      x = v(4'd4); x.reg_we = 1'b1; x.m2r = 2'd1;
      push(1'b1, 1'b0, x);
      while (sb.size() != 0) begin
         e = sb.pop_front();
         tick(e.rdy, e.rst);
         total++;
         if (obs !== e.exp) $display("FAIL load_wait: got %h want %h", obs, e.exp);
         else passed++;
      end
   endtask

   task automatic test_store_fetch_wait();
      opcode = 6'h2B;
      push(1'b0, 1'b0, f_fetch(1'b0));
      push(1'b1, 1'b0, f_fetch(1'b1));
      push(1'b1, 1'b0, f_decode());
      push(1'b1, 1'b0, f_memadr());
      push(1'b1, 1'b0, f_memwr());
      while (sb.size() != 0) begin
         e = sb.pop_front();
         tick(e.rdy, e.rst);
         total++;
         if (obs !== e.exp) $display("FAIL store: got %h want %h", obs, e.exp);
         else passed++;
      end
   endtask

   task automatic test_branch();
      logic [5:0] op_tab [4] = '{6'h04, 6'h05, 6'h04, 6'h05};
      logic       z_tab  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic       we_tab [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      vec_t x;
      for (int k = 0; k < 4; k++) begin
         opcode = op_tab[k];
         zero   = z_tab[k];
         push(1'b1, 1'b0, f_fetch(1'b1));
         push(1'b1, 1'b0, f_decode());
         x = v(4'd10); x.src_a = 1'b1; x.alu_op = 3'b001; x.pc_src = 2'd1; x.pc_we = we_tab[k];
         push(1'b1, 1'b0, x);
         while (sb.size() != 0) begin
            e = sb.pop_front();
            tick(e.rdy, e.rst);
            total++;
            if (obs !== e.exp) $display("FAIL branch op=%h zero=%b: got %h want %h", opcode, zero, obs, e.exp);
            else passed++;
         end
      end
      zero = 1'b0;
   endtask

   task automatic test_imm_ext();
      logic [5:0] op_tab [2] = '{6'h08, 6'h0E};
      logic [2:0] alu_tab[2] = '{3'b000, 3'b010};
      logic       ez_tab [2] = '{1'b0, 1'b1};
      vec_t x;
      for (int k = 0; k < 2; k++) begin
         opcode = op_tab[k];
         push(1'b1, 1'b0, f_fetch(1'b1));
         push(1'b1, 1'b0, f_decode());
         x = v(4'd8); x.src_a = 1'b1; x.src_b = 2'd2; x.alu_op = alu_tab[k]; x.ez = ez_tab[k];
         push(1'b1, 1'b0, x);
         x = v(4'd9); x.reg_we = 1'b1; x.ez = ez_tab[k];
         push(1'b1, 1'b0, x);
         while (sb.size() != 0) begin
            e = sb.pop_front();
            tick(e.rdy, e.rst);
            total++;
            if (obs !== e.exp) $display("FAIL imm op=%h: got %h want %h", opcode, obs, e.exp);
            else passed++;
         end
      end
   endtask

   task automatic test_jumps();
      logic [5:0] op_tab [3] = '{6'h02, 6'h03, 6'h00};
      vec_t x;
      for (int k = 0; k < 3; k++) begin
         opcode = op_tab[k];
         funct  = 6'h08;
         push(1'b1, 1'b0, f_fetch(1'b1));
         push(1'b1, 1'b0, f_decode());
         case (k)
            0: begin x = v(4'd11); x.pc_we = 1'b1; x.pc_src = 2'd2; end
            1: begin
               x = v(4'd12); x.pc_we = 1'b1; x.pc_src = 2'd2;
               x.reg_we = 1'b1; x.reg_dst = 2'd2; x.m2r = 2'd2;
            end
            default: begin x = v(4'd13); x.pc_we = 1'b1; x.pc_src = 2'd3; end
         endcase
         push(1'b1, 1'b0, x);
         while (sb.size() != 0) begin
            e = sb.pop_front();
            tick(e.rdy, e.rst);
            total++;
            if (obs !== e.exp) $display("FAIL jump op=%h: got %h want %h", opcode, obs, e.exp);
            else passed++;
         end
      end
   endtask

   task automatic test_reset_mid_write();
      opcode = 6'h2B;
      push(1'b1, 1'b0, f_fetch(1'b1));
      push(1'b1, 1'b0, f_decode());
      push(1'b1, 1'b0, f_memadr());
      push(1'b0, 1'b0, f_memwr());
      push(1'b0, 1'b0, f_memwr());
      push(1'b1, 1'b1, v(4'd0));
      push(1'b0, 1'b0, f_fetch(1'b0));
      push(1'b1, 1'b0, f_fetch(1'b1));
      push(1'b1, 1'b0, f_decode());
      push(1'b1, 1'b0, f_memadr());
      push(1'b1, 1'b0, f_memwr());
      while (sb.size() != 0) begin
         e = sb.pop_front();
         tick(e.rdy, e.rst);
         total++;
         if (obs !== e.exp) $display("FAIL reset_mid_write: got %h want %h", obs, e.exp);
         else passed++;
      end
   endtask

   task automatic test_halt();
      logic [5:0] op_tab [2] = '{6'h3F, 6'h00};
      logic [5:0] fn_tab [2] = '{6'h00, 6'h21};
      vec_t x;
      for (int k = 0; k < 2; k++) begin
         opcode = op_tab[k];
         funct  = fn_tab[k];
         push(1'b1, 1'b0, f_fetch(1'b1));
         push(1'b1, 1'b0, f_decode());
         x = v(4'd15); x.ill = 1'b1;
         push(1'b1, 1'b0, x);
         push(1'b0, 1'b0, x);
         push(1'b1, 1'b0, x);
         push(1'b1, 1'b1, v(4'd0));
         while (sb.size() != 0) begin
            e = sb.pop_front();
            tick(e.rdy, e.rst);
            total++;
            if (obs !== e.exp) $display("FAIL halt op=%h fn=%h: got %h want %h", opcode, funct, obs, e.exp);
            else passed++;
         end
      end
   endtask

   task automatic test_back_to_back();
      vec_t x;
      opcode = 6'h00;
      funct  = 6'h20;
      push(1'b0, 1'b0, f_fetch(1'b0));
      push(1'b1, 1'b0, f_fetch(1'b1));
      push(1'b1, 1'b0, f_decode());
      x = v(4'd6); x.src_a = 1'b1;
      push(1'b1, 1'b0, x);
      x = v(4'd7); x.reg_we = 1'b1; x.reg_dst = 2'd1;
      push(1'b1, 1'b0, x);
      push(1'b1, 1'b0, f_fetch(1'b1));
      while (sb.size() != 0) begin
         e = sb.pop_front();
         tick(e.rdy, e.rst);
         total++;
         if (obs !== e.exp) $display("FAIL back_to_back: got %h want %h", obs, e.exp);
         else passed++;
      end
   endtask

   initial begin
      reset     = 1'b1;
      mem_ready = 1'b0;
      opcode    = 6'h00;
      funct     = 6'h00;
      zero      = 1'b0;
      test_reset();
      test_rtype();
      test_load_wait();
      test_store_fetch_wait();
      test_branch();
      test_imm_ext();
      test_jumps();
      test_reset_mid_write();
      test_halt();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
